// File: rtl/flit_input_buffer.sv
// Per-port FWFT flit buffer in front of the router. Enforces head/body*/tail
// framing on the write side and tracks how many complete packets are held.
module flit_input_buffer #(
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int AF_LEVEL = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   din,
  input  logic          wr,
  output logic          full,
  output logic          almost_full,
  output logic [15:0]   dout,
  input  logic          rd,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [AW:0]   pkt_count,
  output logic          frame_err,
  output logic          ovf
);

  localparam logic [1:0] TYPE_HEAD = 2'b11;
  localparam logic [1:0] TYPE_BODY = 2'b01;
  localparam logic [1:0] TYPE_TAIL = 2'b10;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  typedef enum logic {
    EXP_HEAD,
    IN_PKT
  } frame_state_t;

  frame_state_t state_q, state_d;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic       wr_accept;
  logic       rd_accept;
  logic       frame_drop;
  logic       wr_tail;
  logic       rd_tail;
  logic [1:0] din_type;

  assign din_type    = din[15:14];
  assign empty       = (count == '0);
  assign full        = (count == FULL_CNT);
  assign almost_full = (count >= AF_CNT);
  assign dout        = empty ? 16'h0000 : mem[rd_ptr];

  assign rd_accept = rd && !empty;
  assign wr_tail   = wr_accept && (din_type == TYPE_TAIL);
  assign rd_tail   = rd_accept && (mem[rd_ptr][15:14] == TYPE_TAIL);

  // Framing is only judged when the flit could otherwise be stored;
  // a write against a full buffer is an overflow, not a framing error.
  always_comb begin
    state_d    = state_q;
    wr_accept  = 1'b0;
    frame_drop = 1'b0;
    if (wr && !full) begin
      unique case (state_q)
        EXP_HEAD: begin
          if (din_type == TYPE_HEAD) begin
            wr_accept = 1'b1;
            state_d   = IN_PKT;
          end else begin
            frame_drop = 1'b1;
          end
        end
        IN_PKT: begin
          if (din_type == TYPE_BODY) begin
            wr_accept = 1'b1;
          end else if (din_type == TYPE_TAIL) begin
            wr_accept = 1'b1;
            state_d   = EXP_HEAD;
          end else begin
            frame_drop = 1'b1;
          end
        end
        default: begin
          frame_drop = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EXP_HEAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Flit storage is deliberately left unreset; empty masks stale contents.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pkt_count <= '0;
      frame_err <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      frame_err <= frame_drop;
      ovf       <= wr && full;
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_accept, rd_accept})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      unique case ({wr_tail, rd_tail})
        2'b10:   pkt_count <= pkt_count + ONE;
        2'b01:   pkt_count <= pkt_count - ONE;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

endmodule
